fpu_sched: RTL and testbench

Two-requester scheduler for the shared 32-bit FPU adder (sign[31], exp[30:20], mant[19:0]; status {exact, overflow, underflow, inexact}).
- Accepts operand pairs from two clients over valid/ready handshakes and arbitrates round-robin.
- Drives the FPU with a start/done handshake and holds operands stable while the FPU works.
- Buffers one result per client and recovers from a hung FPU via a watchdog.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fpu_rr_arb.sv | 22 ++
 rtl/fpu_sched.sv | 113 +++++++++++
 tb/tb_fpu_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU adder scheduler.
// Operand layout: sign[31], exp[30:20], mant[19:0].
package fpu_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 11;
    localparam int MANT_W = 20;
    localparam int ST_W   = 4;

    // Status bit positions inside the 4-bit status word.
    localparam int ST_EXACT = 3;
    localparam int ST_OVF   = 2;
    localparam int ST_UNF   = 1;
    localparam int ST_INEX  = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    function automatic logic [1:0] onehot2(logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Combinational 2-way round-robin arbiter.
// Ports: eligible[1:0], last_grant in; grant_valid, grant_idx out.
module fpu_rr_arb
    import fpu_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        unique case (1'b1)
            (eligible == 2'b11): grant_idx = ~last_grant;
            (eligible == 2'b10): grant_idx = 1'b1;
            default:             grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_sched.sv
// Two-client scheduler for the shared FPU adder with watchdog.
// Ports: req_* (client in), rsp_* (client out), fpu_* (FPU side),
// busy, err_timeout; clock_100k, reset (async, active-low).
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock_100k,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_op_a,
    input  logic [63:0] req_op_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_data,
    output logic [7:0]  rsp_status,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    sched_state_t     state;
    logic             last_grant;
    logic             owner;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_next;
    logic             wd_hit;
    logic [1:0]       eligible;
    logic             grant_valid;
    logic             grant_idx;

    // A full result slot keeps its client out of arbitration.
    assign eligible = req_valid & ~rsp_valid;

    fpu_rr_arb u_arb (
        .eligible    (eligible),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE && grant_valid)
                     ? onehot2(grant_idx) : 2'b00;

    // Abort is decided on the cycle the incremented count hits the
    // limit, so the result lands TIMEOUT_CYCLES after fpu_start.
    assign wd_next = wd_cnt + 1'b1;
    assign wd_hit  = (wd_next == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_100k or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            wd_cnt      <= '0;
            rsp_valid   <= 2'b00;
            rsp_data    <= '0;
            rsp_status  <= '0;
            fpu_op_a    <= '0;
            fpu_op_b    <= '0;
            fpu_start   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            fpu_start   <= 1'b0;
            err_timeout <= 1'b0;
            rsp_valid   <= rsp_valid & ~rsp_ready;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        fpu_op_a  <= req_op_a[{grant_idx, 5'd0} +: FP_W];
                        fpu_op_b  <= req_op_b[{grant_idx, 5'd0} +: FP_W];
                        owner     <= grant_idx;
                        fpu_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_next;
                    if (fpu_done) begin
                        rsp_data[{owner, 5'd0} +: FP_W]  <= fpu_data;
                        rsp_status[{owner, 2'd0} +: ST_W] <= fpu_status;
                        rsp_valid[owner] <= 1'b1;
                        last_grant       <= owner;
                        state            <= IDLE;
                    end else if (wd_hit) begin
                        rsp_data[{owner, 5'd0} +: FP_W]  <= '0;
                        rsp_status[{owner, 2'd0} +: ST_W] <= '0;
                        rsp_valid[owner] <= 1'b1;
                        err_timeout      <= 1'b1;
                        last_grant       <= owner;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched: per-cycle model compare
// plus directed scenarios with hand-computed expectations.
module tb_fpu_sched;

    localparam int TO = 16;

    logic        clock_100k = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req_op_a = '0;
    logic [63:0] req_op_b = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [63:0] rsp_data;
    logic [7:0]  rsp_status;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic        fpu_start;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_data = '0;
    logic [3:0]  fpu_status = '0;
    logic        busy;
    logic        err_timeout;

    fpu_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clock_100k  (clock_100k),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .fpu_op_a    (fpu_op_a),
        .fpu_op_b    (fpu_op_b),
        .fpu_start   (fpu_start),
        .fpu_done    (fpu_done),
        .fpu_data    (fpu_data),
        .fpu_status  (fpu_status),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clock_100k = ~clock_100k;

    int checks = 0;
    int passes = 0;

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // FPU stand-in: answers fpu_lat cycles after fpu_start (0 = never).
    int          fpu_lat = 6;
    int          due = 0;
    logic [31:0] fpu_res = '0;
    logic [3:0]  fpu_st = '0;

    always @(posedge clock_100k) begin
        #1;
        fpu_done = 1'b0;
        if (due > 0) begin
            due--;
            if (due == 0) begin
                fpu_done   = 1'b1;
                fpu_data   = fpu_res;
                fpu_status = fpu_st;
            end
        end
        if (fpu_start && fpu_lat > 0) due = fpu_lat;
    end

    // Behavioural model: one job in flight, two result slots.
    bit          m_active;
    int          m_owner;
    int          m_start;
    bit          m_last;
    logic [1:0]  m_v;
    logic [31:0] m_opa, m_opb;
    logic [31:0] m_data [2];
    logic [3:0]  m_stat [2];
    bit          m_err;
    int          cyc;

    // Observations from the DUT used by the directed checks.
    int          grant_log [$];
    int          n_hs = 0, n_starts = 0, n_err = 0, n_rise = 0;
    int          hs_cyc, start_cyc, err_cyc;
    int          rise_cyc [2];
    logic [31:0] rise_data [2];
    logic [3:0]  rise_stat [2];
    logic [1:0]  prev_v;

    function automatic int pick(logic [1:0] e, bit last);
        if (e == 2'b11) return last ? 0 : 1;
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    always @(negedge clock_100k) begin
        int         g;
        logic [1:0] exp_rr, nv, hs;
        if (!reset) begin
            chk("rst_ctl", {req_ready, rsp_valid, fpu_start, busy,
                            err_timeout}, 0);
            chk("rst_rsp", {rsp_data, rsp_status}, 0);
            chk("rst_ops", {fpu_op_a, fpu_op_b}, 0);
            m_active = 0; m_last = 1; m_v = 0; m_err = 0; cyc = 0;
            prev_v = 0;
        end else begin
            cyc++;
            g = m_active ? -1 : pick(req_valid & ~m_v, m_last);
            exp_rr = (g < 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
            chk("req_ready", req_ready, exp_rr);
            chk("busy", busy, m_active);
            chk("fpu_start", fpu_start, m_active && cyc == m_start);
            chk("rsp_valid", rsp_valid, m_v);
            chk("err_timeout", err_timeout, m_err);
            for (int i = 0; i < 2; i++)
                if (m_v[i]) begin
                    chk("rsp_data", rsp_data[i*32 +: 32], m_data[i]);
                    chk("rsp_status", rsp_status[i*4 +: 4], m_stat[i]);
                end
            if (m_active) chk("fpu_ops", {fpu_op_a, fpu_op_b}, {m_opa, m_opb});

            hs = req_ready & req_valid;
            if (hs != 0) begin
                grant_log.push_back(hs[1] ? 1 : 0);
                n_hs++;
                hs_cyc = cyc;
            end
            if (fpu_start) begin n_starts++; start_cyc = cyc; end
            if (err_timeout) begin n_err++; err_cyc = cyc; end
            for (int i = 0; i < 2; i++)
                if (rsp_valid[i] && !prev_v[i]) begin
                    n_rise++;
                    rise_cyc[i]  = cyc;
                    rise_data[i] = rsp_data[i*32 +: 32];
                    rise_stat[i] = rsp_status[i*4 +: 4];
                end
            prev_v = rsp_valid;

            m_err = 0;
            nv = m_v & ~rsp_ready;
            if (g >= 0) begin
                m_active = 1; m_owner = g; m_start = cyc + 1;
                m_opa = req_op_a[g*32 +: 32];
                m_opb = req_op_b[g*32 +: 32];
            end else if (m_active && cyc > m_start) begin
                if (fpu_done) begin
                    nv[m_owner] = 1'b1;
                    m_data[m_owner] = fpu_data;
                    m_stat[m_owner] = fpu_status;
                    m_last = m_owner[0]; m_active = 0;
                end else if (cyc == m_start + TO - 1) begin
                    nv[m_owner] = 1'b1;
                    m_data[m_owner] = '0;
                    m_stat[m_owner] = '0;
                    m_err = 1; m_last = m_owner[0]; m_active = 0;
                end
            end
            m_v = nv;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clock_100k);
        #1;
    endtask

    task automatic wait_hs(string name);
        int n0;
        n0 = n_hs;
        for (int i = 0; i < 60; i++) begin
            if (n_hs != n0) break;
            step(1);
        end
        chk(name, n_hs != n0, 1);
    endtask

    initial begin
        int b, c0, c1, e0, r0, s0;
        step(3);
        reset = 1'b1;
        step(2);

        // Single request from client 0.
        fpu_lat = 6; fpu_res = 32'h40000000; fpu_st = 4'b1000;
        req_op_a = {32'h0, 32'h3FF00000};
        req_op_b = {32'h0, 32'h3FF00000};
        req_valid = 2'b01;
        wait_hs("t1_hs");
        req_valid = 2'b00;
        step(12);
        chk("t1_start_lat", start_cyc - hs_cyc, 1);
        chk("t1_rsp_lat", rise_cyc[0] - start_cyc, 7);
        chk("t1_data", rise_data[0], 32'h40000000);
        chk("t1_status", rise_stat[0], 4'b1000);

        // Contention: last winner was client 0, so client 1 leads.
        fpu_lat = 3; fpu_res = 32'h40100000; fpu_st = 4'b0001;
        req_op_a = {32'hC0000000, 32'h3FF80000};
        req_op_b = {32'h40080000, 32'hBFF00000};
        b = grant_log.size(); s0 = n_starts;
        req_valid = 2'b11;
        step(40);
        req_valid = 2'b00;
        step(10);
        chk("t2_grants", {grant_log[b], grant_log[b+1], grant_log[b+2],
                          grant_log[b+3]}, {32'd1, 32'd0, 32'd1, 32'd0});
        chk("t2_starts", n_starts - s0, grant_log.size() - b);

        // Back-pressure on client 0.
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        wait_hs("t3_hs");
        req_valid = 2'b00;
        step(12);
        chk("t3_slot_full", rsp_valid[0], 1'b1);
        b = grant_log.size();
        req_valid = 2'b11;
        step(30);
        c0 = 0; c1 = 0;
        for (int k = b; k < grant_log.size(); k++)
            if (grant_log[k] == 0) c0++; else c1++;
        chk("t3_c0_blocked", c0, 0);
        chk("t3_c1_served", c1 >= 3, 1);
        rsp_ready = 2'b11;
        b = grant_log.size();
        step(20);
        c0 = 0;
        for (int k = b; k < grant_log.size(); k++)
            if (grant_log[k] == 0) c0++;
        chk("t3_c0_resumed", c0 >= 1, 1);
        req_valid = 2'b00;
        step(10);

        // Hung FPU.
        fpu_lat = 0;
        req_valid = 2'b01;
        wait_hs("t4_hs");
        req_valid = 2'b00;
        e0 = n_err;
        step(25);
        chk("t4_err_count", n_err - e0, 1);
        chk("t4_err_lat", err_cyc - start_cyc, TO);
        chk("t4_rsp_lat", rise_cyc[0] - start_cyc, TO);
        chk("t4_data", {rise_data[0], rise_stat[0]}, 0);
        chk("t4_busy", busy, 1'b0);

        // Reset during WAIT, FPU answers after release.
        fpu_lat = 10; fpu_res = 32'h7FF00000; fpu_st = 4'b0100;
        req_valid = 2'b01;
        wait_hs("t5_hs");
        req_valid = 2'b00;
        step(4);
        chk("t5_busy_pre", busy, 1'b1);
        r0 = n_rise; e0 = n_err;
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        step(15);
        chk("t5_no_rsp", n_rise - r0, 0);
        chk("t5_no_err", n_err - e0, 0);
        fpu_lat = 5; fpu_res = 32'h3FF00000; fpu_st = 4'b1001;
        b = grant_log.size();
        req_valid = 2'b11;
        wait_hs("t5_hs2");
        req_valid = 2'b00;
        step(12);
        chk("t5_first_grant", grant_log[b], 0);
        chk("t5_rsp_lat", rise_cyc[0] - start_cyc, 6);
        chk("t5_data", {rise_data[0], rise_stat[0]}, {32'h3FF00000, 4'b1001});

        // Done on the last watchdog cycle.
        fpu_lat = TO - 1; fpu_res = 32'h00100000; fpu_st = 4'b0011;
        req_valid = 2'b01;
        wait_hs("t6_hs");
        req_valid = 2'b00;
        e0 = n_err;
        step(25);
        chk("t6_no_err", n_err - e0, 0);
        chk("t6_rsp_lat", rise_cyc[0] - start_cyc, TO);
        chk("t6_data", {rise_data[0], rise_stat[0]}, {32'h00100000, 4'b0011});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
